// File: rtl/riscv_pkg.sv
// Shared RV32I fetch-side definitions: bubble instruction, instruction-memory
// FSM states and a small PC alignment helper.
package riscv_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    PROG  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one synchronous read
// port with read-enable, written so it infers a block RAM.
module imem_array #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/instr_mem_sync.sv
// Writable, synchronous-read instruction memory between the PC and IF/ID:
// self-clearing after reset, runtime programming port, stall/flush-aware fetch.
import riscv_pkg::*;

module instr_mem_sync #(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [INS_W-1:0] NOP_WORD    = RV_NOP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INS_ADDRESS-1:0] ra,
  input  logic                   req,
  input  logic                   stall,
  input  logic                   flush,
  output logic [INS_W-1:0]       rd,
  output logic                   rd_valid,
  output logic                   misalign,
  input  logic                   prog_en,
  input  logic                   prog_we,
  input  logic [INS_ADDRESS-3:0] prog_addr,
  input  logic [INS_W-1:0]       prog_data,
  output logic                   mem_ready
);

  localparam int            AW       = INS_ADDRESS - 2;
  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  imem_state_t      r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic             r_from_mem;
  logic             r_rd_valid;
  logic             r_misalign;
  logic             r_mem_ready;

  logic             w_aligned;
  logic             w_re;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [INS_W-1:0] w_wdata;
  logic [INS_W-1:0] w_rdata;

  assign w_aligned = word_aligned(ra[1:0]);

  // The RAM output register doubles as the fetch data register: it only
  // reloads on a real aligned fetch, so stalls hold it for free.
  assign w_re = (r_state == RUN) && !prog_en && !flush && !stall && req && w_aligned;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = prog_addr;
    w_wdata = prog_data;
    if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = NOP_WORD;
    end else if (r_state == PROG) begin
      w_we    = prog_we;
    end
  end

  imem_array #(
    .AW (AW),
    .DW (INS_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (ra[INS_ADDRESS-1:2]),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_from_mem  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_misalign  <= 1'b0;
      r_mem_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_from_mem <= 1'b0;
          r_rd_valid <= 1'b0;
          r_misalign <= 1'b0;
          if (r_clr_cnt == CLR_LAST) begin
            r_state     <= prog_en ? PROG : RUN;
            r_mem_ready <= !prog_en;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        PROG: begin
          r_from_mem <= 1'b0;
          r_rd_valid <= 1'b0;
          r_misalign <= 1'b0;
          if (!prog_en) begin
            r_state     <= RUN;
            r_mem_ready <= 1'b1;
          end
        end
        RUN: begin
          if (prog_en) begin
            r_state     <= PROG;
            r_mem_ready <= 1'b0;
            r_from_mem  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_misalign  <= 1'b0;
          end else if (flush) begin
            r_from_mem <= 1'b0;
            r_rd_valid <= 1'b0;
            r_misalign <= 1'b0;
          end else if (!stall) begin
            r_from_mem <= req && w_aligned;
            r_rd_valid <= req;
            r_misalign <= req && !w_aligned;
          end
        end
        default: begin
          r_state     <= CLEAR;
          r_clr_cnt   <= '0;
          r_from_mem  <= 1'b0;
          r_rd_valid  <= 1'b0;
          r_misalign  <= 1'b0;
          r_mem_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rd        = r_from_mem ? w_rdata : NOP_WORD;
  assign rd_valid  = r_rd_valid;
  assign misalign  = r_misalign;
  assign mem_ready = r_mem_ready;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: a word-array model predicts outputs every
// cycle, and literal expectations pin the headline scenarios.
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  ra = '0;
  logic        req = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        prog_en = 1'b0, prog_we = 1'b0;
  logic [6:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [31:0] rd;
  logic        rd_valid, misalign, mem_ready;

  instr_mem_sync dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .req       (req),
    .stall     (stall),
    .flush     (flush),
    .rd        (rd),
    .rd_valid  (rd_valid),
    .misalign  (misalign),
    .prog_en   (prog_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: 0 = clearing, 1 = programming, 2 = running
  int          m_mode;
  int          m_left;
  logic [31:0] m_mem [128];
  logic [31:0] e_rd;
  logic        e_v, e_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic bubble();
    e_rd = NOP; e_v = 1'b0; e_m = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_left = 128;
    bubble();
  endtask

  task automatic model_edge();
    if (m_mode == 0) begin
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < 128; i++) m_mem[i] = NOP;
        m_mode = prog_en ? 1 : 2;
      end
      bubble();
    end else if (m_mode == 1) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (!prog_en) m_mode = 2;
      bubble();
    end else begin
      if (prog_en) begin
        m_mode = 1;
        bubble();
      end else if (flush) begin
        bubble();
      end else if (stall) begin
        // outputs hold
      end else if (req) begin
        if (ra % 4 == 0) begin
          e_rd = m_mem[(ra / 4) % 128]; e_v = 1'b1; e_m = 1'b0;
        end else begin
          e_rd = NOP; e_v = 1'b1; e_m = 1'b1;
        end
      end else begin
        bubble();
      end
    end
  endtask

  task automatic compare();
    chk("rd", rd, e_rd);
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_v});
    chk("misalign", {31'b0, misalign}, {31'b0, e_m});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, (m_mode == 2)});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 compare();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: clear takes exactly 128 cycles, then fetch from the top word
    repeat (127) cyc();
    chk("ready_after_127", {31'b0, mem_ready}, 32'd0);
    cyc();
    chk("ready_after_128", {31'b0, mem_ready}, 32'd1);
    req = 1'b1; ra = 9'h1FC;
    cyc();
    chk("fetch_1fc_rd", rd, NOP);
    chk("fetch_1fc_valid", {31'b0, rd_valid}, 32'd1);
    req = 1'b0;

    // 2: program two words, then fetch them
    prog_en = 1'b1;
    cyc();
    chk("prog_ready_low", {31'b0, mem_ready}, 32'd0);
    prog_we = 1'b1; prog_addr = 7'd1; prog_data = 32'h0010_0093;
    cyc();
    prog_addr = 7'd2; prog_data = 32'h0040_8213;
    cyc();
    prog_we = 1'b0; prog_en = 1'b0;
    cyc();
    chk("run_ready_high", {31'b0, mem_ready}, 32'd1);
    req = 1'b1; ra = 9'd4;
    cyc();
    chk("fetch_w1", rd, 32'h0010_0093);
    ra = 9'd8;
    cyc();
    chk("fetch_w2", rd, 32'h0040_8213);
    chk("fetch_w2_valid", {31'b0, rd_valid}, 32'd1);

    // 3: stall holds across changing ra, flush beats stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra = 9'(4 + 4 * i);
      cyc();
      chk("stall_hold_rd", rd, 32'h0040_8213);
      chk("stall_hold_valid", {31'b0, rd_valid}, 32'd1);
    end
    flush = 1'b1;
    cyc();
    chk("flush_rd", rd, NOP);
    chk("flush_valid", {31'b0, rd_valid}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // 4: misaligned fetch then aligned fetch
    ra = 9'd6;
    cyc();
    chk("mis_rd", rd, NOP);
    chk("mis_valid", {31'b0, rd_valid}, 32'd1);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    ra = 9'd8;
    cyc();
    chk("aligned_flag", {31'b0, misalign}, 32'd0);
    chk("aligned_rd", rd, 32'h0040_8213);
    req = 1'b0;

    // 5: reset mid-PROG wipes programmed word; prog_we during clear is ignored
    prog_en = 1'b1;
    cyc();
    prog_we = 1'b1; prog_addr = 7'd1; prog_data = 32'hDEAD_BEEF;
    cyc();
    prog_en = 1'b0; prog_addr = 7'd2; prog_data = 32'hCAFE_BABE;
    do_reset();
    repeat (128) cyc();
    prog_we = 1'b0;
    chk("reclear_ready", {31'b0, mem_ready}, 32'd1);
    req = 1'b1; ra = 9'd4;
    cyc();
    chk("wiped_w1", rd, NOP);
    ra = 9'd8;
    cyc();
    chk("clear_we_ignored", rd, NOP);
    chk("clear_we_valid", {31'b0, rd_valid}, 32'd1);

    // 6: entering PROG during a fetch drops it
    ra = 9'd0; prog_en = 1'b1;
    cyc();
    chk("enter_prog_ready", {31'b0, mem_ready}, 32'd0);
    chk("enter_prog_valid", {31'b0, rd_valid}, 32'd0);
    prog_en = 1'b0; req = 1'b0;
    cyc();

    // 7: prog_en held through clear lands in PROG
    prog_en = 1'b1;
    do_reset();
    repeat (128) cyc();
    chk("clear_to_prog_ready", {31'b0, mem_ready}, 32'd0);
    prog_en = 1'b0;
    cyc();
    chk("prog_to_run_ready", {31'b0, mem_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
